div3_sequence_generator: RTL and testbench
==========================================

DIV3_SEQUENCE_GENERATOR -- requirements
Module: div3_sequence_generator

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset; forces all state to reset values immediately.
REQ-004 start  input  1  request a new sequence; sampled only in IDLE.
REQ-005 stop  input  1  abort the current sequence; sampled in IDLE and EMIT.
REQ-006 dir  input  1  0 = ascending 0,3,6,9,12,15; 1 = descending 15,12,9,6,3,0; captured at start.
REQ-007 loop  input  1  1 = restart the sequence after the last value instead of finishing; sampled live on each accept.
REQ-008 out  output  4  current multiple of three offered to the consumer.
REQ-009 out_valid  output  1  out holds a valid value.
REQ-010 out_ready  input  1  consumer accepts out when out_valid and out_ready are both high at a rising edge.
REQ-011 busy  output  1  high in EMIT and DONE.
REQ-012 done  output  1  one-cycle pulse after the sixth value of a non-looping sequence is accepted.
REQ-013 seq_cnt  output  3  index 0..5 of the value currently on out.
REQ-014 err  output  1  sticky flag; set when out_valid is high and out is not divisible by 3.

Function
REQ-015 The FSM SHALL have three states: IDLE, EMIT and DONE.
REQ-016 IDLE, start=1, stop=0: next edge enters EMIT with out=0 (dir=0) or 15 (dir=1), seq_cnt=0, out_valid=1; start-to-valid latency is 1 cycle.
REQ-017 IDLE, start=1, stop=1: stop wins; the block stays in IDLE.
REQ-018 EMIT, out_valid=1, out_ready=0: out, seq_cnt and out_valid SHALL hold stable.
REQ-019 EMIT, accept with seq_cnt<5: out becomes out+3 (dir=0) or out-3 (dir=1), seq_cnt increments, out_valid stays 1; back-to-back accepts every cycle.
REQ-020 EMIT, accept with seq_cnt=5 and loop=0: enter DONE, out_valid=0, done=1 for that cycle, out holds the last value.
REQ-021 EMIT, accept with seq_cnt=5 and loop=1: out wraps to the first value for the captured dir, seq_cnt=0, out_valid stays 1, no done.
REQ-022 DONE SHALL last exactly one cycle, then return to IDLE; start during DONE is ignored.
REQ-023 EMIT, stop=1: next edge enters IDLE with out_valid=0 and no done; a handshake completing in the same cycle counts as transferred; out and seq_cnt hold.
REQ-024 start during EMIT SHALL be ignored.
REQ-025 dir changes after start SHALL NOT affect the running sequence.
REQ-026 Arithmetic SHALL be 4-bit and never overflow: the ascending maximum is 15 and the descending minimum is 0.
REQ-027 err SHALL be computed from out with a mod-3 check, set at the edge where the violation is observed, and cleared only by rst.

Reset
REQ-028 While rst=1: state=IDLE, out=0, out_valid=0, busy=0, done=0, seq_cnt=0, err=0, captured dir=0.
REQ-029 rst asserted mid-sequence SHALL abort immediately with no done pulse; after release the block waits in IDLE for start.

Verification
REQ-030 Ascending run: dir=0, loop=0, out_ready=1, start pulse -> out 0,3,6,9,12,15 on 6 consecutive cycles, seq_cnt 0..5, done one cycle after the value 15 is accepted, busy low on the next cycle.
REQ-031 Backpressure: dir=1, out_ready toggled 1,0,0,1,... -> each value 15,12,9,6,3,0 is held stable while ready=0, no value is skipped or repeated, and done pulses once.
REQ-032 Looping: dir=0, loop=1, out_ready=1 for 14 cycles -> 0,3,...,15,0,3,...,15,0,3; no done; at cycle 14, deassert loop and let the sequence finish -> done after the next value 15 is accepted.
REQ-033 Abort: stop at seq_cnt=2 (out=6) -> out_valid=0 next cycle, out=6 and seq_cnt=2 held, done never pulses, and a fresh start restarts from 0.
REQ-034 Collisions: start+stop together in IDLE -> stays IDLE; start during EMIT or DONE -> no restart; dir flipped mid-run -> the running sequence is unchanged.
REQ-035 Reset: rst asserted asynchronously between edges at out=9 -> all outputs go to their reset values immediately; err=0 throughout all scenarios.

Source files
------------

// File: rtl/div3_sequence_generator.sv
// -----------------------------------------------------------------------------
// div3_sequence_generator
//
// Emits the six 4-bit multiples of three (0,3,6,9,12,15) over a valid/ready
// handshake. The order is ascending or descending, chosen by dir when the
// sequence starts. The sequence can be restarted automatically (loop) or
// aborted (stop). A sticky err flag watches the offered value for
// divisibility by three.
//
// Ports
//   clk        in   1  rising-edge clock for all state
//   rst        in   1  asynchronous active-high reset
//   start      in   1  request a new sequence (only looked at in IDLE)
//   stop       in   1  abort; wins over start in IDLE, ends EMIT
//   dir        in   1  0 = ascending, 1 = descending; captured at start
//   loop       in   1  wrap to the first value after the sixth accept
//   out        out  4  value currently offered
//   out_valid  out  1  out holds a valid value
//   out_ready  in   1  consumer accepts when out_valid && out_ready
//   busy       out  1  high in EMIT and DONE
//   done       out  1  one-cycle pulse after a non-looping sequence ends
//   seq_cnt    out  3  index 0..5 of the value on out
//   err        out  1  sticky: out_valid with out not a multiple of three
// -----------------------------------------------------------------------------
module div3_sequence_generator (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       dir,
  input  logic       loop,
  output logic [3:0] out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       done,
  output logic [2:0] seq_cnt,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_r;
  logic       dir_r;
  logic [3:0] next_out_s;
  logic [3:0] first_out_s;
  logic       accept_s;
  logic       last_s;
  logic       bad_value_s;

  // Residue check: true when value is not a multiple of three.
  function automatic logic not_div3(input logic [3:0] value);
    logic [3:0] rem;
    rem = value % 4'd3;
    return (rem != 4'd0);
  endfunction

  // Next value in the running sequence and its first value, both following
  // the captured direction. The step is only used while seq_cnt < 5, so the
  // results stay within 0..15 without wrapping.
  always_comb begin
    next_out_s  = out;
    first_out_s = 4'd0;
    if (dir_r) begin
      next_out_s  = out - 4'd3;
      first_out_s = 4'd15;
    end else begin
      next_out_s  = out + 4'd3;
      first_out_s = 4'd0;
    end
  end

  // Handshake and end-of-sequence qualifiers.
  always_comb begin
    accept_s    = out_valid & out_ready;
    last_s      = (seq_cnt == 3'd5);
    bad_value_s = out_valid & not_div3(out);
  end

  // Sequencer FSM; every output is registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      dir_r     <= 1'b0;
      out       <= 4'd0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      seq_cnt   <= 3'd0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (bad_value_s) begin
        err <= 1'b1;
      end

      case (state_r)
        IDLE: begin
          // stop has priority so a start+stop collision leaves us idle.
          if (!stop && start) begin
            state_r   <= EMIT;
            dir_r     <= dir;
            out       <= dir ? 4'd15 : 4'd0;
            seq_cnt   <= 3'd0;
            out_valid <= 1'b1;
            busy      <= 1'b1;
          end
        end

        EMIT: begin
          if (stop) begin
            // A handshake in this same cycle is considered delivered, but
            // out and seq_cnt are left showing the last offered value.
            state_r   <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end else if (accept_s) begin
            if (!last_s) begin
              out     <= next_out_s;
              seq_cnt <= seq_cnt + 3'd1;
            end else if (loop) begin
              out     <= first_out_s;
              seq_cnt <= 3'd0;
            end else begin
              state_r   <= DONE;
              out_valid <= 1'b0;
              done      <= 1'b1;
            end
          end
        end

        DONE: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end

        default: begin
          state_r   <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div3_sequence_generator.sv
module tb_div3_sequence_generator;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic       dir;
  logic       loop;
  logic [3:0] out;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       done;
  logic [2:0] seq_cnt;
  logic       err;

  int n_checks = 0;
  int n_fail   = 0;

  div3_sequence_generator dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .dir       (dir),
    .loop      (loop),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .seq_cnt   (seq_cnt),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_checks++;
    if (out !== 4'd0 || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        seq_cnt !== 3'd0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: out=%0d valid=%b busy=%b done=%b seq=%0d err=%b, required all zero",
               out, out_valid, busy, done, seq_cnt, err);
    end
    tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: valid=%b busy=%b, required 0 0", out_valid, busy);
    end
  endtask

  task automatic test_ascending();
    dir = 1'b0; loop = 1'b0; out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (out !== 4'(3 * i) || seq_cnt !== 3'(i) || out_valid !== 1'b1 ||
          busy !== 1'b1 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL asc_value[%0d]: out=%0d seq=%0d valid=%b busy=%b done=%b, required %0d %0d 1 1 0",
                 i, out, seq_cnt, out_valid, busy, done, 3 * i, i);
      end
      tick();
    end
    n_checks++;
    if (done !== 1'b1 || out_valid !== 1'b0 || out !== 4'd15 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL asc_done: done=%b valid=%b out=%0d busy=%b, required 1 0 15 1",
               done, out_valid, out, busy);
    end
    tick();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL asc_after: done=%b busy=%b err=%b, required 0 0 0", done, busy, err);
    end
  endtask

  task automatic test_backpressure();
    int done_count;
    done_count = 0;
    dir = 1'b1; loop = 1'b0; out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    dir = 1'b0;
    for (int i = 0; i < 6; i++) begin
      out_ready = 1'b0;
      for (int h = 0; h < 3; h++) begin
        n_checks++;
        if (out !== 4'(15 - 3 * i) || seq_cnt !== 3'(i) || out_valid !== 1'b1 || done !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_hold[%0d.%0d]: out=%0d seq=%0d valid=%b done=%b, required %0d %0d 1 0",
                   i, h, out, seq_cnt, out_valid, done, 15 - 3 * i, i);
        end
        if (h < 2) tick();
      end
      out_ready = 1'b1;
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      if (done === 1'b1) done_count++;
      tick();
    end
    n_checks++;
    if (done_count != 1 || busy !== 1'b0 || out !== 4'd0) begin
      n_fail++;
      $display("FAIL bp_done: pulses=%0d busy=%b out=%0d, required 1 0 0", done_count, busy, out);
    end
  endtask

  task automatic test_loop();
    dir = 1'b0; loop = 1'b1; out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 14; c++) begin
      n_checks++;
      if (out !== 4'(3 * (c % 6)) || seq_cnt !== 3'(c % 6) || out_valid !== 1'b1 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL loop_value[%0d]: out=%0d seq=%0d valid=%b done=%b, required %0d %0d 1 0",
                 c, out, seq_cnt, out_valid, done, 3 * (c % 6), c % 6);
      end
      tick();
    end
    loop = 1'b0;
    for (int j = 2; j < 6; j++) begin
      n_checks++;
      if (out !== 4'(3 * j) || seq_cnt !== 3'(j) || done !== 1'b0) begin
        n_fail++;
        $display("FAIL loop_tail[%0d]: out=%0d seq=%0d done=%b, required %0d %0d 0",
                 j, out, seq_cnt, done, 3 * j, j);
      end
      tick();
    end
    n_checks++;
    if (done !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL loop_done: done=%b valid=%b, required 1 0", done, out_valid);
    end
    tick();
  endtask

  task automatic test_abort();
    dir = 1'b0; loop = 1'b0; out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    n_checks++;
    if (out !== 4'd6 || seq_cnt !== 3'd2) begin
      n_fail++;
      $display("FAIL abort_pre: out=%0d seq=%0d, required 6 2", out, seq_cnt);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (out_valid !== 1'b0 || out !== 4'd6 || seq_cnt !== 3'd2 || done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_hold[%0d]: valid=%b out=%0d seq=%0d done=%b busy=%b, required 0 6 2 0 0",
                 k, out_valid, out, seq_cnt, done, busy);
      end
      tick();
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if (out !== 4'd0 || seq_cnt !== 3'd0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_restart: out=%0d seq=%0d valid=%b, required 0 0 1", out, seq_cnt, out_valid);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
  endtask

  task automatic test_collisions();
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL coll_start_stop: valid=%b busy=%b, required 0 0", out_valid, busy);
    end
    dir = 1'b0; loop = 1'b0; out_ready = 1'b0; start = 1'b1;
    tick();
    dir = 1'b1;
    tick();
    n_checks++;
    if (out !== 4'd0 || seq_cnt !== 3'd0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL coll_start_emit: out=%0d seq=%0d valid=%b, required 0 0 1", out, seq_cnt, out_valid);
    end
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (out !== 4'd3 || seq_cnt !== 3'd1) begin
      n_fail++;
      $display("FAIL coll_dir_flip: out=%0d seq=%0d, required 3 1", out, seq_cnt);
    end
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    n_checks++;
    if (out !== 4'd15 || seq_cnt !== 3'd5) begin
      n_fail++;
      $display("FAIL coll_last: out=%0d seq=%0d, required 15 5", out, seq_cnt);
    end
    tick();
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL coll_done: done=%b, required 1", done);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL coll_start_done: valid=%b busy=%b done=%b, required 0 0 0", out_valid, busy, done);
    end
    tick();
  endtask

  task automatic test_async_reset();
    dir = 1'b0; loop = 1'b0; out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    n_checks++;
    if (out !== 4'd9 || seq_cnt !== 3'd3 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_pre: out=%0d seq=%0d err=%b, required 9 3 0", out, seq_cnt, err);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (out !== 4'd0 || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        seq_cnt !== 3'd0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_async: out=%0d valid=%b busy=%b done=%b seq=%0d err=%b, required all zero",
               out, out_valid, busy, done, seq_cnt, err);
    end
    #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_idle[%0d]: valid=%b busy=%b done=%b, required 0 0 0", k, out_valid, busy, done);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; dir = 1'b0; loop = 1'b0; out_ready = 1'b0;
    #1;
    test_reset();
    test_ascending();
    test_backpressure();
    test_loop();
    test_abort();
    test_collisions();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
